// File: rtl/sl811_bus_ctl.sv
// sl811_bus_ctl: arbitrates two requesters onto the SL811 indirect-addressed port and runs each grant as an address-write + data access.
// Define SL811_RR_ARB_EN for round-robin arbitration; default build uses fixed priority (port 0 wins).
module sl811_bus_ctl #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rnw0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdat0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rnw1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdat1,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       sl_a0,
  output logic       sl_cs_n,
  output logic       sl_rd_n,
  output logic       sl_wr_n,
  output logic [7:0] sl_d_out,
  output logic       sl_d_oe,
  input  logic [7:0] sl_d_in,
  input  logic       sl_intrq,
  output logic       irq
);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, DONE
  } state_t;

  localparam logic [7:0] SET_LD = 8'(T_SETUP - 1);
  localparam logic [7:0] STB_LD = 8'(T_STROBE - 1);
  localparam logic [7:0] HLD_LD = 8'(T_HOLD - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       lat_rnw, lat_rnw_nxt;
  logic       lat_gnt, lat_gnt_nxt;
  logic [7:0] lat_addr, lat_addr_nxt;
  logic [7:0] lat_wdat, lat_wdat_nxt;
  logic       take, gnt_sel;
  logic       a0_nxt, cs_n_nxt, rd_n_nxt, wr_n_nxt, d_oe_nxt;
  logic       ack0_nxt, ack1_nxt;
  logic [7:0] d_out_nxt;
  logic       irq_meta;

`ifdef SL811_RR_ARB_EN
  // rr_pri names the port that wins the next simultaneous request
  logic rr_pri;

  always_comb begin
    take = req0 | req1;
    if (req0 && req1) gnt_sel = rr_pri;
    else              gnt_sel = ~req0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        rr_pri <= 1'b0;
    else if (state == IDLE && take) rr_pri <= ~gnt_sel;
  end
`else
  always_comb begin
    take    = req0 | req1;
    gnt_sel = ~req0;
  end
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_rnw_nxt  = lat_rnw;
    lat_gnt_nxt  = lat_gnt;
    lat_addr_nxt = lat_addr;
    lat_wdat_nxt = lat_wdat;
    if (state != IDLE && state != DONE && cnt != 8'd0) begin
      cnt_nxt = cnt - 8'd1;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state_nxt    = A_SET;
            cnt_nxt      = SET_LD;
            lat_gnt_nxt  = gnt_sel;
            lat_rnw_nxt  = gnt_sel ? rnw1  : rnw0;
            lat_addr_nxt = gnt_sel ? addr1 : addr0;
            lat_wdat_nxt = gnt_sel ? wdat1 : wdat0;
          end
        end
        A_SET: begin state_nxt = A_STB; cnt_nxt = STB_LD; end
        A_STB: begin state_nxt = A_HLD; cnt_nxt = HLD_LD; end
        A_HLD: begin state_nxt = D_SET; cnt_nxt = SET_LD; end
        D_SET: begin state_nxt = D_STB; cnt_nxt = STB_LD; end
        D_STB: begin state_nxt = D_HLD; cnt_nxt = HLD_LD; end
        D_HLD: begin state_nxt = DONE;  cnt_nxt = 8'd0;   end
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pin values are decoded from the next state so they register in step with it
  always_comb begin
    a0_nxt    = 1'b0;
    cs_n_nxt  = 1'b1;
    rd_n_nxt  = 1'b1;
    wr_n_nxt  = 1'b1;
    d_out_nxt = 8'h00;
    d_oe_nxt  = 1'b0;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    case (state_nxt)
      A_SET, A_HLD: begin
        d_out_nxt = lat_addr_nxt;
        d_oe_nxt  = 1'b1;
      end
      A_STB: begin
        d_out_nxt = lat_addr_nxt;
        d_oe_nxt  = 1'b1;
        cs_n_nxt  = 1'b0;
        wr_n_nxt  = 1'b0;
      end
      D_SET, D_HLD: begin
        a0_nxt = 1'b1;
        if (!lat_rnw_nxt) begin
          d_out_nxt = lat_wdat_nxt;
          d_oe_nxt  = 1'b1;
        end
      end
      D_STB: begin
        a0_nxt   = 1'b1;
        cs_n_nxt = 1'b0;
        if (lat_rnw_nxt) begin
          rd_n_nxt = 1'b0;
        end else begin
          wr_n_nxt  = 1'b0;
          d_out_nxt = lat_wdat_nxt;
          d_oe_nxt  = 1'b1;
        end
      end
      DONE: begin
        ack0_nxt = ~lat_gnt_nxt;
        ack1_nxt = lat_gnt_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      lat_rnw  <= 1'b0;
      lat_gnt  <= 1'b0;
      lat_addr <= 8'h00;
      lat_wdat <= 8'h00;
      sl_a0    <= 1'b0;
      sl_cs_n  <= 1'b1;
      sl_rd_n  <= 1'b1;
      sl_wr_n  <= 1'b1;
      sl_d_out <= 8'h00;
      sl_d_oe  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= 8'h00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_rnw  <= lat_rnw_nxt;
      lat_gnt  <= lat_gnt_nxt;
      lat_addr <= lat_addr_nxt;
      lat_wdat <= lat_wdat_nxt;
      sl_a0    <= a0_nxt;
      sl_cs_n  <= cs_n_nxt;
      sl_rd_n  <= rd_n_nxt;
      sl_wr_n  <= wr_n_nxt;
      sl_d_out <= d_out_nxt;
      sl_d_oe  <= d_oe_nxt;
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      // Sample the pad on the last strobe cycle, while rd_n is still low
      if (state == D_STB && cnt == 8'd0 && lat_rnw) rdata <= sl_d_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_meta <= sl_intrq;
      irq      <= irq_meta;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sl811_bus_ctl.sv
// tb_sl811_bus_ctl: directed checks of sl811_bus_ctl (default timing instance plus a T_SETUP=2/T_STROBE=1/T_HOLD=2 instance).
module tb_sl811_bus_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, rnw0, req1, rnw1;
  logic [7:0] addr0, wdat0, addr1, wdat1;
  logic       ack0, ack1, busy;
  logic [7:0] rdata;
  logic       sl_a0, sl_cs_n, sl_rd_n, sl_wr_n, sl_d_oe;
  logic [7:0] sl_d_out, sl_d_in;
  logic       sl_intrq, irq;
  logic [7:0] model_val;

  logic       req_p;
  logic       p_ack0, p_ack1, p_busy, p_a0, p_cs_n, p_rd_n, p_wr_n, p_d_oe, p_irq;
  logic [7:0] p_rdata, p_d_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  int cyc, wr_lo_a, wr_lo_d, rd_lo, cs_stray, a0_oe, n_ack0, n_ack1;
  logic [7:0] d_a, d_d;

  always #5 clk = ~clk;

  // SL811 model: drives model_val only while a read strobe is active
  assign sl_d_in = (!sl_cs_n && !sl_rd_n) ? model_val : 8'h00;

  sl811_bus_ctl u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdat0(wdat0), .ack0(ack0),
    .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdat1(wdat1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .sl_a0(sl_a0), .sl_cs_n(sl_cs_n), .sl_rd_n(sl_rd_n), .sl_wr_n(sl_wr_n),
    .sl_d_out(sl_d_out), .sl_d_oe(sl_d_oe), .sl_d_in(sl_d_in),
    .sl_intrq(sl_intrq), .irq(irq)
  );

  sl811_bus_ctl #(.T_SETUP(2), .T_STROBE(1), .T_HOLD(2)) u_p (
    .clk(clk), .rst(rst),
    .req0(req_p), .rnw0(rnw0), .addr0(addr0), .wdat0(wdat0), .ack0(p_ack0),
    .req1(1'b0), .rnw1(1'b0), .addr1(8'h00), .wdat1(8'h00), .ack1(p_ack1),
    .rdata(p_rdata), .busy(p_busy),
    .sl_a0(p_a0), .sl_cs_n(p_cs_n), .sl_rd_n(p_rd_n), .sl_wr_n(p_wr_n),
    .sl_d_out(p_d_out), .sl_d_oe(p_d_oe), .sl_d_in(8'h00),
    .sl_intrq(1'b0), .irq(p_irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; wr_lo_a = 0; wr_lo_d = 0; rd_lo = 0; cs_stray = 0; a0_oe = 0;
    n_ack0 = 0; n_ack1 = 0; d_a = 8'h00; d_d = 8'h00;
  endtask

  // Advance one clock and accumulate what the SL811 pins did in that cycle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!sl_cs_n && !sl_wr_n && !sl_a0) begin wr_lo_a++; d_a = sl_d_out; end
    if (!sl_cs_n && !sl_wr_n && sl_a0)  begin wr_lo_d++; d_d = sl_d_out; end
    if (!sl_cs_n && !sl_rd_n) rd_lo++;
    if (!sl_cs_n && sl_rd_n && sl_wr_n) cs_stray++;
    if (sl_a0 && sl_d_oe) a0_oe++;
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
  endtask

  // One request on one port; req dropped right after ack is seen
  task automatic applyStimulus(input logic port, input logic rnw, input logic [7:0] addr,
                               input logic [7:0] wdat, output int lat, output logic [7:0] rd_at_ack);
    clear_stats();
    lat = 0;
    rd_at_ack = 8'h00;
    if (port) begin rnw1 = rnw; addr1 = addr; wdat1 = wdat; req1 = 1'b1; end
    else      begin rnw0 = rnw; addr0 = addr; wdat0 = wdat; req0 = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      step();
      if ((port && ack1) || (!port && ack0)) begin
        lat = cyc;
        rd_at_ack = rdata;
        req0 = 1'b0;
        req1 = 1'b0;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
  endtask

  initial begin
    int lat, acks, first_cyc, second_cyc, pw_a, pw_d;
    logic first_port, second_port, exp_second;
    logic [7:0] rda;
    logic [3:0] irq_seen;

    rst = 1'b1; req0 = 0; req1 = 0; rnw0 = 0; rnw1 = 0; req_p = 0;
    addr0 = 0; wdat0 = 0; addr1 = 0; wdat1 = 0; sl_intrq = 0; model_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_strobes", {sl_cs_n, sl_rd_n, sl_wr_n}, 3'b111);
    checkOutput("rst_a0_oe", {sl_a0, sl_d_oe}, 2'b00);
    checkOutput("rst_dout", sl_d_out, 8'h00);
    checkOutput("rst_ack_busy_irq", {ack0, ack1, busy, irq}, 4'b0000);
    checkOutput("rst_rdata", rdata, 8'h00);
    rst = 1'b0;

    $display("[TB] port 0 write");
    applyStimulus(1'b0, 1'b0, 8'h05, 8'hA5, lat, rda);
    checkOutput("wr_latency", lat, 11);
    checkOutput("wr_addr_strobe_len", wr_lo_a, 3);
    checkOutput("wr_data_strobe_len", wr_lo_d, 3);
    checkOutput("wr_addr_value", d_a, 8'h05);
    checkOutput("wr_data_value", d_d, 8'hA5);
    checkOutput("wr_cs_stray", cs_stray, 0);
    checkOutput("wr_ack0_cycles", n_ack0, 1);
    checkOutput("wr_ack1_cycles", n_ack1, 0);
    checkOutput("wr_idle_after", busy, 1'b0);

    $display("[TB] port 1 read");
    model_val = 8'h3C;
    applyStimulus(1'b1, 1'b1, 8'h0D, 8'h00, lat, rda);
    checkOutput("rd_latency", lat, 11);
    checkOutput("rd_addr_value", d_a, 8'h0D);
    checkOutput("rd_strobe_len", rd_lo, 3);
    checkOutput("rd_data_oe", a0_oe, 0);
    checkOutput("rd_no_write", wr_lo_d, 0);
    checkOutput("rd_rdata_at_ack", rda, 8'h3C);
    checkOutput("rd_rdata_held", rdata, 8'h3C);
    checkOutput("rd_ack_cycles", {n_ack0[3:0], n_ack1[3:0]}, 8'h01);

    $display("[TB] simultaneous requests held");
`ifdef SL811_RR_ARB_EN
    exp_second = 1'b1;
`else
    exp_second = 1'b0;
`endif
    clear_stats();
    rnw0 = 0; addr0 = 8'h11; wdat0 = 8'h01;
    rnw1 = 0; addr1 = 8'h22; wdat1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    acks = 0; first_cyc = 0; second_cyc = 0; first_port = 1'b1; second_port = 1'bx;
    for (int i = 0; i < 60 && acks < 2; i++) begin
      step();
      if (ack0 || ack1) begin
        if (acks == 0) begin
          first_port = ack1; first_cyc = cyc;
        end else begin
          second_port = ack1; second_cyc = cyc; req0 = 1'b0; req1 = 1'b0;
        end
        acks++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    checkOutput("arb_ack_count", acks, 2);
    checkOutput("arb_first_port", first_port, 1'b0);
    checkOutput("arb_first_latency", first_cyc, 11);
    checkOutput("arb_second_port", second_port, exp_second);
    checkOutput("arb_gap", second_cyc - first_cyc, 12);
    checkOutput("arb_second_addr", d_a, exp_second ? 8'h22 : 8'h11);

    $display("[TB] reset during address strobe");
    clear_stats();
    rnw0 = 0; addr0 = 8'h33; wdat0 = 8'h44; req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!sl_wr_n && !sl_a0) break;
    end
    checkOutput("mid_in_astb", {sl_cs_n, sl_wr_n, sl_a0}, 3'b000);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_strobes_high", {sl_cs_n, sl_wr_n, sl_rd_n}, 3'b111);
    checkOutput("mid_oe_busy", {sl_d_oe, busy}, 2'b00);
    req0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    repeat (15) step();
    checkOutput("mid_no_ack", n_ack0 + n_ack1, 0);
    checkOutput("mid_rdata_cleared", rdata, 8'h00);
    model_val = 8'h5A;
    applyStimulus(1'b0, 1'b1, 8'h0D, 8'h00, lat, rda);
    checkOutput("mid_fresh_latency", lat, 11);
    checkOutput("mid_fresh_rdata", rda, 8'h5A);
    checkOutput("mid_fresh_ack0", n_ack0, 1);

    $display("[TB] T_SETUP=2 T_STROBE=1 T_HOLD=2 write");
    rnw0 = 0; addr0 = 8'h07; wdat0 = 8'h96;
    req_p = 1'b1;
    lat = 0; pw_a = 0; pw_d = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!p_cs_n && !p_wr_n) begin
        if (p_a0) pw_d++;
        else      pw_a++;
      end
      if (p_ack0) begin lat = i + 1; req_p = 1'b0; break; end
    end
    req_p = 1'b0;
    checkOutput("par_latency", lat, 11);
    checkOutput("par_addr_strobe_len", pw_a, 1);
    checkOutput("par_data_strobe_len", pw_d, 1);
    @(posedge clk);
    #1;
    checkOutput("par_ack_pulse", {p_ack0, p_ack1}, 2'b00);

    $display("[TB] intrq synchroniser");
    sl_intrq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      sl_intrq = 1'b0;
      irq_seen[i] = irq;
    end
    checkOutput("irq_pattern", irq_seen, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
